// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the UART TX FIFO write port; a grant is held for a whole message and dropped by a stall watchdog.
// One cycle from request to grant, then one byte per cycle. A full FIFO or uart_en=0 drops req_ready combinationally.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          uart_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          tx_fifo_full,
  output logic                          tx_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         tx_fifo_wr_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          timeout_err,
  output logic [IDW-1:0]                timeout_id
);

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

  arb_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [7:0]             stall_cnt_q, stall_cnt_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [IDW-1:0]         timeout_id_q, timeout_id_d;

  logic [IDW-1:0]         owner;
  logic [IDW-1:0]         pick_idx;
  logic                   pick_vld;
  logic [DATA_WIDTH-1:0]  owner_data;
  logic                   locked;
  logic                   can_xfer;
  logic                   accept;

  function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] v);
    if (int'(v) == NUM_REQ - 1) return '0;
    return v + IDW'(1);
  endfunction

  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) owner = IDW'(i);
    end
  end

  // Upward search from rr_ptr, wrapping, first valid requester wins.
  always_comb begin
    logic [IDW-1:0] idx;
    idx      = rr_ptr_q;
    pick_vld = 1'b0;
    pick_idx = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_vld && req_valid[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
      idx = inc_wrap(idx);
    end
  end

  assign locked          = (state_q == ARB_LOCKED);
  assign owner_data      = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
  assign can_xfer        = locked & uart_en & ~tx_fifo_full;
  assign accept          = can_xfer & req_valid[owner];

  assign req_ready       = can_xfer ? grant_q : '0;
  assign tx_fifo_wr_en   = accept;
  assign tx_fifo_wr_data = locked ? owner_data : '0;
  assign grant           = grant_q;
  assign busy            = locked;
  assign timeout_err     = timeout_err_q;
  assign timeout_id      = timeout_id_q;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    stall_cnt_d   = stall_cnt_q;
    timeout_err_d = 1'b0;
    timeout_id_d  = timeout_id_q;
    case (state_q)
      ARB_IDLE: begin
        grant_d = '0;
        if (uart_en && pick_vld) begin
          grant_d[pick_idx] = 1'b1;
          stall_cnt_d       = '0;
          state_d           = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (accept && req_last[owner]) begin
          state_d     = ARB_IDLE;
          grant_d     = '0;
          rr_ptr_d    = inc_wrap(owner);
          stall_cnt_d = '0;
        end else if (req_valid[owner]) begin
          // A valid byte held back by a full FIFO is not a stall.
          stall_cnt_d = '0;
        end else if (uart_en) begin
          if (stall_cnt_q == 8'(TIMEOUT - 1)) begin
            state_d       = ARB_IDLE;
            grant_d       = '0;
            rr_ptr_d      = inc_wrap(owner);
            stall_cnt_d   = '0;
            timeout_err_d = 1'b1;
            timeout_id_d  = owner;
          end else begin
            stall_cnt_d = stall_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      stall_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
      timeout_id_q  <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      stall_cnt_q   <= stall_cnt_d;
      timeout_err_q <= timeout_err_d;
      timeout_id_q  <= timeout_id_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with four requesters and a short stall limit.
module tb_uart_tx_arbiter;

  logic        clock;
  logic        reset_n;
  logic        uart_en;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_fifo_full;
  logic        tx_fifo_wr_en;
  logic [7:0]  tx_fifo_wr_data;
  logic [3:0]  grant;
  logic        busy;
  logic        timeout_err;
  logic [1:0]  timeout_id;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .TIMEOUT(4)) dut (
    .clock(clock), .reset_n(reset_n), .uart_en(uart_en),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_fifo_full(tx_fifo_full),
    .tx_fifo_wr_en(tx_fifo_wr_en), .tx_fifo_wr_data(tx_fifo_wr_data),
    .grant(grant), .busy(busy), .timeout_err(timeout_err), .timeout_id(timeout_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; uart_en = 1'b1; tx_fifo_full = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    #2;
    n_cmp++;
    if ({grant, busy, req_ready, tx_fifo_wr_en} !== 10'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0", {grant, busy, req_ready, tx_fifo_wr_en});
    end
    n_cmp++;
    if ({tx_fifo_wr_data, timeout_err, timeout_id} !== 11'b0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", {tx_fifo_wr_data, timeout_err, timeout_id});
    end
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic test_single_msg();
    req_valid = 4'b0100; req_data[16 +: 8] = 8'h41; req_last = 4'b0000;
    @(negedge clock);
    n_cmp++;
    if (grant !== 4'b0000 || tx_fifo_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: grant %b wr_en %b want 0000 0", grant, tx_fifo_wr_en);
    end
    tick();
    @(negedge clock);
    n_cmp++;
    if ({grant, req_ready, busy} !== {4'b0100, 4'b0100, 1'b1}) begin
      n_fail++; $display("FAIL single_grant: got %b want 0100_0100_1", {grant, req_ready, busy});
    end
    n_cmp++;
    if (tx_fifo_wr_en !== 1'b1 || tx_fifo_wr_data !== 8'h41) begin
      n_fail++; $display("FAIL single_b0: wr_en %b data %h want 1 41", tx_fifo_wr_en, tx_fifo_wr_data);
    end
    tick();
    req_data[16 +: 8] = 8'h42;
    @(negedge clock);
    n_cmp++;
    if (tx_fifo_wr_en !== 1'b1 || tx_fifo_wr_data !== 8'h42) begin
      n_fail++; $display("FAIL single_b1: wr_en %b data %h want 1 42", tx_fifo_wr_en, tx_fifo_wr_data);
    end
    tick();
    req_data[16 +: 8] = 8'h43; req_last = 4'b0100;
    @(negedge clock);
    n_cmp++;
    if (tx_fifo_wr_en !== 1'b1 || tx_fifo_wr_data !== 8'h43) begin
      n_fail++; $display("FAIL single_b2: wr_en %b data %h want 1 43", tx_fifo_wr_en, tx_fifo_wr_data);
    end
    tick();
    req_valid = '0; req_last = '0;
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      n_fail++; $display("FAIL single_release: busy %b grant %b want 0 0000", busy, grant);
    end
    tick();
    // rr_ptr must now be 3: with 0 and 3 both requesting, 3 wins.
    req_valid = 4'b1001; req_data[0 +: 8] = 8'h01; req_data[24 +: 8] = 8'h31; req_last = 4'b1001;
    @(negedge clock);
    tick();
    @(negedge clock);
    n_cmp++;
    if (grant !== 4'b1000 || tx_fifo_wr_data !== 8'h31) begin
      n_fail++; $display("FAIL rr_ptr_3: grant %b data %h want 1000 31", grant, tx_fifo_wr_data);
    end
    tick();
    req_valid = '0; req_last = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int cnt [4];
    int exp_id;
    logic [7:0] exp_byte;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    req_valid = 4'b1111;
    for (int m = 0; m < 5; m++) begin
      exp_id = m % 4;
      for (int c = 0; c < 3; c++) begin
        for (int i = 0; i < 4; i++) begin
          req_data[i*8 +: 8] = 8'((i + 1) * 16 + cnt[i]);
          req_last[i]        = (cnt[i] % 2 == 1);
        end
        @(negedge clock);
        if (c == 0) begin
          n_cmp++;
          if (grant !== 4'b0000 || tx_fifo_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL rr_gap m%0d: grant %b wr_en %b want 0000 0", m, grant, tx_fifo_wr_en);
          end
        end else begin
          exp_byte = 8'((exp_id + 1) * 16 + cnt[exp_id]);
          n_cmp++;
          if (grant !== 4'(1 << exp_id) || tx_fifo_wr_en !== 1'b1 || tx_fifo_wr_data !== exp_byte) begin
            n_fail++;
            $display("FAIL rr_msg m%0d b%0d: grant %b wr_en %b data %h want %b 1 %h",
                     m, c - 1, grant, tx_fifo_wr_en, tx_fifo_wr_data, 4'(1 << exp_id), exp_byte);
          end
        end
        tick();
        if (c != 0) cnt[exp_id]++;
      end
    end
    req_valid = '0; req_last = '0;
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL rr_end_busy: got %b want 0", busy);
    end
    tick();
  endtask

  task automatic test_fifo_full();
    req_valid = 4'b0010; req_data[8 +: 8] = 8'hA0; req_last = '0;
    @(negedge clock);
    tick();
    @(negedge clock);
    n_cmp++;
    if (grant !== 4'b0010 || tx_fifo_wr_en !== 1'b1 || tx_fifo_wr_data !== 8'hA0) begin
      n_fail++; $display("FAIL full_b0: grant %b wr_en %b data %h want 0010 1 a0", grant, tx_fifo_wr_en, tx_fifo_wr_data);
    end
    tick();
    req_data[8 +: 8] = 8'hA1; tx_fifo_full = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      n_cmp++;
      if ({req_ready, tx_fifo_wr_en, timeout_err, grant} !== {4'b0000, 1'b0, 1'b0, 4'b0010}) begin
        n_fail++; $display("FAIL full_hold c%0d: ready/wr/err/grant %b want 0000_0_0_0010", c,
                           {req_ready, tx_fifo_wr_en, timeout_err, grant});
      end
      tick();
    end
    tx_fifo_full = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (req_ready !== 4'b0010 || tx_fifo_wr_en !== 1'b1 || tx_fifo_wr_data !== 8'hA1) begin
      n_fail++; $display("FAIL full_resume: ready %b wr_en %b data %h want 0010 1 a1", req_ready, tx_fifo_wr_en, tx_fifo_wr_data);
    end
    tick();
    req_data[8 +: 8] = 8'hA2; req_last = 4'b0010;
    @(negedge clock);
    n_cmp++;
    if (tx_fifo_wr_en !== 1'b1 || tx_fifo_wr_data !== 8'hA2) begin
      n_fail++; $display("FAIL full_last: wr_en %b data %h want 1 a2", tx_fifo_wr_en, tx_fifo_wr_data);
    end
    tick();
    req_valid = '0; req_last = '0;
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL full_end: busy %b err %b want 0 0", busy, timeout_err);
    end
    tick();
  endtask

  task automatic test_timeout();
    req_valid = 4'b0010; req_data[8 +: 8] = 8'hB0; req_last = '0;
    @(negedge clock);
    tick();
    @(negedge clock);
    n_cmp++;
    if (grant !== 4'b0010 || tx_fifo_wr_data !== 8'hB0 || tx_fifo_wr_en !== 1'b1) begin
      n_fail++; $display("FAIL to_b0: grant %b wr_en %b data %h want 0010 1 b0", grant, tx_fifo_wr_en, tx_fifo_wr_data);
    end
    tick();
    req_valid = 4'b0100; req_data[16 +: 8] = 8'hC0; req_last = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      n_cmp++;
      if ({grant, tx_fifo_wr_en, timeout_err} !== {4'b0010, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL to_stall c%0d: grant/wr/err %b want 0010_0_0", c, {grant, tx_fifo_wr_en, timeout_err});
      end
      tick();
    end
    @(negedge clock);
    n_cmp++;
    if ({timeout_err, timeout_id, grant, busy} !== {1'b1, 2'd1, 4'b0000, 1'b0}) begin
      n_fail++; $display("FAIL to_release: err/id/grant/busy %b want 1_01_0000_0", {timeout_err, timeout_id, grant, busy});
    end
    tick();
    @(negedge clock);
    n_cmp++;
    if ({grant, tx_fifo_wr_en, tx_fifo_wr_data} !== {4'b0100, 1'b1, 8'hC0}) begin
      n_fail++; $display("FAIL to_next: grant %b wr_en %b data %h want 0100 1 c0", grant, tx_fifo_wr_en, tx_fifo_wr_data);
    end
    n_cmp++;
    if (timeout_err !== 1'b0 || timeout_id !== 2'd1) begin
      n_fail++; $display("FAIL to_pulse: err %b id %0d want 0 1", timeout_err, timeout_id);
    end
    tick();
    req_valid = '0; req_last = '0;
    tick();
  endtask

  task automatic test_uart_en();
    req_valid = 4'b1000; req_data[24 +: 8] = 8'hD0; req_last = '0;
    @(negedge clock);
    tick();
    @(negedge clock);
    n_cmp++;
    if (grant !== 4'b1000 || tx_fifo_wr_data !== 8'hD0 || tx_fifo_wr_en !== 1'b1) begin
      n_fail++; $display("FAIL en_b0: grant %b wr_en %b data %h want 1000 1 d0", grant, tx_fifo_wr_en, tx_fifo_wr_data);
    end
    tick();
    uart_en = 1'b0; req_valid = 4'b0001; req_data[0 +: 8] = 8'hE0; req_last = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      n_cmp++;
      if ({req_ready, grant, tx_fifo_wr_en, timeout_err, busy} !== {4'b0000, 4'b1000, 1'b0, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL en_off c%0d: ready/grant/wr/err/busy %b want 0000_1000_0_0_1", c,
                           {req_ready, grant, tx_fifo_wr_en, timeout_err, busy});
      end
      tick();
    end
    uart_en = 1'b1; req_valid = 4'b1001; req_data[24 +: 8] = 8'hD1; req_last = 4'b1001;
    @(negedge clock);
    n_cmp++;
    if ({grant, tx_fifo_wr_en, tx_fifo_wr_data, timeout_err} !== {4'b1000, 1'b1, 8'hD1, 1'b0}) begin
      n_fail++; $display("FAIL en_resume: grant %b wr_en %b data %h err %b want 1000 1 d1 0",
                         grant, tx_fifo_wr_en, tx_fifo_wr_data, timeout_err);
    end
    tick();
    req_valid = 4'b0001;
    @(negedge clock);
    n_cmp++;
    if (grant !== 4'b0000 || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL en_gap: grant %b err %b want 0000 0", grant, timeout_err);
    end
    tick();
    @(negedge clock);
    n_cmp++;
    if (grant !== 4'b0001 || tx_fifo_wr_data !== 8'hE0) begin
      n_fail++; $display("FAIL en_next: grant %b data %h want 0001 e0", grant, tx_fifo_wr_data);
    end
    tick();
    req_valid = '0; req_last = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0100; req_data[16 +: 8] = 8'hF0; req_last = '0;
    @(negedge clock);
    tick();
    @(negedge clock);
    n_cmp++;
    if (grant !== 4'b0100 || tx_fifo_wr_data !== 8'hF0) begin
      n_fail++; $display("FAIL rst_pre: grant %b data %h want 0100 f0", grant, tx_fifo_wr_data);
    end
    tick();
    req_data[16 +: 8] = 8'hF1;
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({grant, busy, req_ready, tx_fifo_wr_en} !== 10'b0) begin
      n_fail++; $display("FAIL rst_mid_ctrl: got %b want 0", {grant, busy, req_ready, tx_fifo_wr_en});
    end
    n_cmp++;
    if ({tx_fifo_wr_data, timeout_err, timeout_id} !== 11'b0) begin
      n_fail++; $display("FAIL rst_mid_data: got %h want 0", {tx_fifo_wr_data, timeout_err, timeout_id});
    end
    tick();
    reset_n = 1'b1;
    req_valid = 4'b0111; req_data[0 +: 8] = 8'h55; req_last = 4'b0111;
    @(negedge clock);
    n_cmp++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_idle: grant %b busy %b want 0000 0", grant, busy);
    end
    tick();
    @(negedge clock);
    n_cmp++;
    if (grant !== 4'b0001 || tx_fifo_wr_data !== 8'h55) begin
      n_fail++; $display("FAIL rst_restart: grant %b data %h want 0001 55", grant, tx_fifo_wr_data);
    end
    tick();
    req_valid = '0; req_last = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_msg();
    test_round_robin();
    test_fifo_full();
    test_timeout();
    test_uart_en();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
